scan_decoder: RTL and testbench

- Parametrised, registered successor to the team's 3-to-8 enable-gated decoder.
- Decodes a SEL_W-bit select into NUM_OUT one-hot lines, gated by a three-input enable (g1 & ~ga_n & ~gb_n).
- Adds an auto-scan mode: an internal prescaled counter steps the select through 0..NUM_OUT-1, as needed for multiplexed LED/7-seg digit driving.
- Sits between the display-data path and the board's digit-select pins.

---
 rtl/scan_decoder_pkg.sv | 21 ++
 rtl/scan_decoder_prescaler.sv | 29 ++
 rtl/scan_decoder.sv | 91 +++++++++
 tb/tb_scan_decoder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared types, mode constants and the one-hot decode helper for scan_decoder.
package scan_decoder_pkg;

  typedef enum logic {
    DIRECT = 1'b0,
    SCAN   = 1'b1
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest decode supported (SEL_W <= 5); callers truncate to NUM_OUT bits.
  localparam int MAX_OUT = 32;

  function automatic logic [MAX_OUT-1:0] onehot_dec(input int unsigned sel,
                                                     input int unsigned num_out);
    if (sel < num_out && sel < MAX_OUT) return 32'd1 << sel;
    return '0;
  endfunction

endpackage

// File: rtl/scan_decoder_prescaler.sv
// Scan-step prescaler: counts 0..PRESCALE-1 while enabled; clear wins over enable.
module scan_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);
  localparam int CNT_W = $clog2(PRESCALE) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] r_cnt;

  // tick marks the cycle whose enabled edge completes a scan step
  assign o_tick = (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= o_tick ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered enable-gated decoder with direct-load and auto-scan modes.
// Build option SCAN_DECODER_ACTIVE_LOW_EN inverts y (74138-style outputs).
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W    = 3,
  parameter int NUM_OUT  = 8,
  parameter int PRESCALE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               g1,
  input  logic               ga_n,
  input  logic               gb_n,
  input  logic               mode,
  input  logic               load,
  input  logic [SEL_W-1:0]   sel_in,
  output logic [NUM_OUT-1:0] y,
  output logic [SEL_W-1:0]   sel_out,
  output logic               wrap,
  output state_t             dbg_state
);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_OUT - 1);

  state_t             r_state, w_state_next;
  logic [SEL_W-1:0]   r_sel, w_sel_next;
  logic [NUM_OUT-1:0] r_y, w_y_next;
  logic               r_wrap, w_wrap_next;
  logic               w_en, w_ps_clear, w_ps_tick;

  assign w_en = g1 & ~ga_n & ~gb_n;
  // Prescaler only runs while staying in SCAN; any entry/exit edge zeroes it.
  assign w_ps_clear = !(r_state == SCAN && mode == MODE_SCAN);

  scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_ps_clear),
    .i_enable (w_en),
    .o_tick   (w_ps_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= DIRECT;
      r_sel   <= '0;
      r_y     <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
      r_y     <= w_y_next;
      r_wrap  <= w_wrap_next;
    end
  end

  always_comb begin
    w_state_next = (mode == MODE_SCAN) ? SCAN : DIRECT;
    w_sel_next   = r_sel;
    w_wrap_next  = 1'b0;
    if (r_state == DIRECT) begin
      if (mode == MODE_SCAN) begin
        w_sel_next = (32'(r_sel) < unsigned'(NUM_OUT)) ? r_sel : '0;
      end else if (load) begin
        w_sel_next = sel_in;
      end
    end else begin
      // Leaving SCAN ignores load and suppresses any pending step.
      if (mode == MODE_SCAN && w_en && w_ps_tick) begin
        if (r_sel == LAST_SEL) begin
          w_sel_next  = '0;
          w_wrap_next = 1'b1;
        end else begin
          w_sel_next = r_sel + SEL_W'(1);
        end
      end
    end
    w_y_next = w_en ? NUM_OUT'(onehot_dec(32'(w_sel_next), unsigned'(NUM_OUT))) : '0;
  end

`ifdef SCAN_DECODER_ACTIVE_LOW_EN
  assign y = ~r_y;
`else
  assign y = r_y;
`endif

  assign sel_out   = r_sel;
  assign wrap      = r_wrap;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: reset, direct decode, range, scan timing, hold, async reset.
module tb_scan_decoder;
  import scan_decoder_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       g1 = 1'b1, ga_n = 1'b0, gb_n = 1'b0;
  logic       mode = 1'b0, load = 1'b0;
  logic [2:0] sel_in = 3'd0;

  logic [7:0] y;
  logic [2:0] sel_out;
  logic       wrap;
  state_t     st;

  logic [5:0] y6;
  logic [2:0] sel_out6;
  logic       wrap6;
  state_t     st6;

  int checks = 0;
  int errors = 0;
  int wraps  = 0;

  scan_decoder #(.SEL_W(3), .NUM_OUT(8), .PRESCALE(4)) u_dut (
    .clk(clk), .rst(rst), .g1(g1), .ga_n(ga_n), .gb_n(gb_n), .mode(mode),
    .load(load), .sel_in(sel_in), .y(y), .sel_out(sel_out), .wrap(wrap),
    .dbg_state(st)
  );

  scan_decoder #(.SEL_W(3), .NUM_OUT(6), .PRESCALE(4)) u_dut6 (
    .clk(clk), .rst(rst), .g1(g1), .ga_n(ga_n), .gb_n(gb_n), .mode(mode),
    .load(load), .sel_in(sel_in), .y(y6), .sel_out(sel_out6), .wrap(wrap6),
    .dbg_state(st6)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp8(input logic [7:0] v);
`ifdef SCAN_DECODER_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  function automatic logic [5:0] exp6(input logic [5:0] v);
`ifdef SCAN_DECODER_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held across edges
    repeat (2) @(posedge clk);
    #1;
    chk8("rst_y", y, exp8(8'h00));
    chk6("rst_y6", y6, exp6(6'h00));
    chk3("rst_sel", sel_out, 3'd0);
    chk1("rst_wrap", wrap, 1'b0);
    chk1("rst_state", st, DIRECT);

    // Release: first edge decodes sel 0 in DIRECT
    rst = 1'b0;
    tick();
    chk8("rel_y", y, exp8(8'h01));
    chk1("rel_state", st, DIRECT);

    // Direct decode and enable gating
    load = 1'b1; sel_in = 3'd3;
    tick();
    chk8("dir3_y", y, exp8(8'h08));
    chk3("dir3_sel", sel_out, 3'd3);
    load = 1'b0; gb_n = 1'b1;
    tick();
    chk8("dis_y", y, exp8(8'h00));
    chk3("dis_sel", sel_out, 3'd3);
    gb_n = 1'b0; ga_n = 1'b1; load = 1'b1; sel_in = 3'd5;
    tick();
    chk8("dis_load_y", y, exp8(8'h00));
    chk3("dis_load_sel", sel_out, 3'd5);
    ga_n = 1'b0; load = 1'b0;
    tick();
    chk8("en_back_y", y, exp8(8'h20));

    // Out of range on the NUM_OUT=6 instance
    load = 1'b1; sel_in = 3'd7;
    tick();
    chk8("oor_y8", y, exp8(8'h80));
    chk6("oor_y6", y6, exp6(6'h00));
    chk3("oor_sel6", sel_out6, 3'd7);
    load = 1'b0; mode = 1'b1;
    tick();
    chk6("entry_y6", y6, exp6(6'h01));
    chk3("entry_sel6", sel_out6, 3'd0);
    chk1("entry_state6", st6, SCAN);
    chk1("entry_wrap6", wrap6, 1'b0);
    chk3("entry_sel8", sel_out, 3'd7);
    chk8("entry_y8", y, exp8(8'h80));
    chk1("entry_state8", st, SCAN);

    // Back to DIRECT, load 0, then enter SCAN from sel 0
    mode = 1'b0;
    tick();
    chk1("exit_state", st, DIRECT);
    chk3("exit_sel", sel_out, 3'd7);
    load = 1'b1; sel_in = 3'd0;
    tick();
    load = 1'b0; mode = 1'b1;
    tick();
    chk8("scan0_y", y, exp8(8'h01));
    chk1("scan0_wrap", wrap, 1'b0);

    // Scan timing: step every 4 enabled cycles, one wrap at edge 32
    for (int i = 1; i <= 32; i++) begin
      logic [7:0] oh;
      tick();
      oh = 8'h01 << ((i / 4) % 8);
      chk3("scan_sel", sel_out, 3'((i / 4) % 8));
      chk8("scan_y", y, exp8(oh));
      chk1("scan_wrap", wrap, (i == 32));
      if (wrap) wraps++;
    end
    checks++;
    assert (wraps == 1) else begin
      errors++;
      $error("FAIL wrap_count: observed %0d expected 1", wraps);
    end
    tick();
    chk1("wrap_drop", wrap, 1'b0);
    chk3("post_wrap_sel", sel_out, 3'd0);

    // Reach sel=2 with prescaler=1, then hold with g1 low
    repeat (8) tick();
    chk3("hold_start_sel", sel_out, 3'd2);
    g1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk8("hold_y", y, exp8(8'h00));
      chk3("hold_sel", sel_out, 3'd2);
    end
    g1 = 1'b1;
    tick();
    chk8("resume1_y", y, exp8(8'h04));
    tick();
    chk8("resume2_y", y, exp8(8'h04));
    tick();
    chk8("resume3_y", y, exp8(8'h08));
    chk3("resume3_sel", sel_out, 3'd3);

    // Mode change on a step edge wins; load on that edge is ignored
    repeat (3) tick();
    chk3("prestep_sel", sel_out, 3'd3);
    mode = 1'b0; load = 1'b1; sel_in = 3'd6;
    tick();
    chk1("mc_state", st, DIRECT);
    chk3("mc_sel", sel_out, 3'd3);
    chk8("mc_y", y, exp8(8'h08));
    tick();
    chk3("mc_load_sel", sel_out, 3'd6);
    chk8("mc_load_y", y, exp8(8'h40));

    // Async reset mid-scan at sel 5
    sel_in = 3'd5;
    tick();
    load = 1'b0; mode = 1'b1;
    tick();
    chk8("pre_rst_y", y, exp8(8'h20));
    chk1("pre_rst_state", st, SCAN);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk8("async_y", y, exp8(8'h00));
    chk3("async_sel", sel_out, 3'd0);
    chk1("async_wrap", wrap, 1'b0);
    chk1("async_state", st, DIRECT);
    mode = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk1("post_rst_state", st, DIRECT);
    tick();
    chk1("post_rel_state", st, DIRECT);
    chk8("post_rel_y", y, exp8(8'h01));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
